fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks a fetch pointer through a combinational
// program ROM and buffers up to two {instruction, pc} pairs for the decoder.
// Supports single-cycle redirect (JUMP) and a stop-fetch state (HALT_REQ).
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [15:0] ROM_ADDR,
    input  logic [15:0] ROM_DATA,
    output logic [15:0] INST,
    output logic [15:0] INST_PC,
    output logic        INST_VALID,
    input  logic        INST_READY,
    input  logic        JUMP,
    input  logic [15:0] JUMP_ADDR,
    input  logic        HALT_REQ,
    output logic        STOPPED
);

    typedef enum logic {
        StRun  = 1'b0,
        StStop = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_d;
    logic [15:0] r_fpc;
    logic [15:0] w_fpc_d;
    logic [1:0]  r_count;
    logic [1:0]  w_count_d;
    logic [15:0] r_inst0;
    logic [15:0] r_inst1;
    logic [15:0] r_pc0;
    logic [15:0] r_pc1;
    logic [15:0] w_inst0_d;
    logic [15:0] w_inst1_d;
    logic [15:0] w_pc0_d;
    logic [15:0] w_pc1_d;
    logic        r_stopped;
    logic        w_pop;
    logic        w_push;
    logic        w_push_slot0;

    // State register, fetch pointer, FIFO storage and the STOPPED flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= StRun;
            r_fpc     <= RESET_PC;
            r_count   <= 2'd0;
            r_inst0   <= 16'h0000;
            r_inst1   <= 16'h0000;
            r_pc0     <= 16'h0000;
            r_pc1     <= 16'h0000;
            r_stopped <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_fpc     <= w_fpc_d;
            r_count   <= w_count_d;
            r_inst0   <= w_inst0_d;
            r_inst1   <= w_inst1_d;
            r_pc0     <= w_pc0_d;
            r_pc1     <= w_pc1_d;
            // Tracks the state register exactly, so it rises with the move to STOP.
            r_stopped <= (w_state_d == StStop);
        end
    end

    // Next-state logic: JUMP always returns to RUN and beats HALT_REQ.
    always_comb begin
        w_state_d = r_state;
        if (JUMP) begin
            w_state_d = StRun;
        end else if ((r_state == StRun) && HALT_REQ) begin
            w_state_d = StStop;
        end
    end

    // Pop/push decisions and FIFO/fetch-pointer next values.
    always_comb begin
        w_pop        = (r_count != 2'd0) && INST_READY && !JUMP;
        w_push       = (r_state == StRun) && !JUMP && !HALT_REQ &&
                       ((r_count != 2'd2) || w_pop);
        // New entry lands in slot 0 when the buffer is (or becomes) empty.
        w_push_slot0 = (r_count == 2'd0) || ((r_count == 2'd1) && w_pop);

        w_fpc_d   = r_fpc;
        w_count_d = r_count;
        w_inst0_d = r_inst0;
        w_inst1_d = r_inst1;
        w_pc0_d   = r_pc0;
        w_pc1_d   = r_pc1;

        if (JUMP) begin
            w_fpc_d   = JUMP_ADDR;
            w_count_d = 2'd0;
        end else begin
            if (w_pop) begin
                w_inst0_d = r_inst1;
                w_pc0_d   = r_pc1;
            end
            if (w_push) begin
                w_fpc_d = r_fpc + 16'd1;
                if (w_push_slot0) begin
                    w_inst0_d = ROM_DATA;
                    w_pc0_d   = r_fpc;
                end else begin
                    w_inst1_d = ROM_DATA;
                    w_pc1_d   = r_fpc;
                end
            end
            w_count_d = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Head entry is masked to zero whenever the buffer is empty.
    always_comb begin
        ROM_ADDR   = r_fpc;
        INST_VALID = (r_count != 2'd0);
        INST       = INST_VALID ? r_inst0 : 16'h0000;
        INST_PC    = INST_VALID ? r_pc0 : 16'h0000;
        STOPPED    = r_stopped;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a monitor pops expected PCs from a
// scoreboard queue on every accepted instruction; scenario tasks add direct checks.
module tb_fetch_unit;

    logic        CLK;
    logic        RST_N;
    logic [15:0] ROM_ADDR;
    logic [15:0] ROM_DATA;
    logic [15:0] INST;
    logic [15:0] INST_PC;
    logic        INST_VALID;
    logic        INST_READY;
    logic        JUMP;
    logic [15:0] JUMP_ADDR;
    logic        HALT_REQ;
    logic        STOPPED;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;
    logic [15:0] sb_pc[$];

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_DATA   (ROM_DATA),
        .INST       (INST),
        .INST_PC    (INST_PC),
        .INST_VALID (INST_VALID),
        .INST_READY (INST_READY),
        .JUMP       (JUMP),
        .JUMP_ADDR  (JUMP_ADDR),
        .HALT_REQ   (HALT_REQ),
        .STOPPED    (STOPPED)
    );

    function automatic logic [15:0] rom_f(input logic [15:0] a);
        case (a)
            16'h0000: rom_f = 16'h5C00;
            16'h0001: rom_f = 16'h80C9;
            16'h0002: rom_f = 16'h6240;
            default:  rom_f = (a * 16'd3) ^ 16'h1234;
        endcase
    endfunction

    assign ROM_DATA = rom_f(ROM_ADDR);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard monitor: a handshake seen at the falling edge pops at the next rising edge.
    always @(negedge CLK) begin
        logic [15:0] e_pc;
        if (RST_N && INST_VALID && INST_READY && !JUMP) begin
            n_pop++;
            total++;
            if (sb_pc.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got pc=%h inst=%h, expected none", INST_PC, INST);
            end else begin
                e_pc = sb_pc.pop_front();
                if (INST_PC !== e_pc || INST !== rom_f(e_pc)) begin
                    bad++;
                    $display("FAIL sb_entry: got pc=%h inst=%h, expected pc=%h inst=%h",
                             INST_PC, INST, e_pc, rom_f(e_pc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; INST_READY = 1'b0; JUMP = 1'b0; JUMP_ADDR = 16'h0; HALT_REQ = 1'b0;
        #2;
        total++; if (INST_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", INST_VALID); end
        total++; if (INST !== 16'h0) begin bad++; $display("FAIL rst_inst: got %h want 0000", INST); end
        total++; if (INST_PC !== 16'h0) begin bad++; $display("FAIL rst_pc: got %h want 0000", INST_PC); end
        total++; if (STOPPED !== 1'b0) begin bad++; $display("FAIL rst_stopped: got %b want 0", STOPPED); end
        total++; if (ROM_ADDR !== 16'h0) begin bad++; $display("FAIL rst_addr: got %h want 0000", ROM_ADDR); end
    endtask

    task automatic test_stream();
        logic [15:0] lit[3] = '{16'h5C00, 16'h80C9, 16'h6240};
        int n0;
        tick();
        for (int i = 0; i < 6; i++) sb_pc.push_back(16'(i));
        n0 = n_pop;
        INST_READY = 1'b1;
        RST_N = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            total++; if (INST_VALID !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, INST_VALID); end
            if (i < 3) begin
                total++;
                if (INST !== lit[i] || INST_PC !== 16'(i)) begin
                    bad++; $display("FAIL stream_word[%0d]: got %h@%h want %h@%h", i, INST, INST_PC, lit[i], 16'(i));
                end
            end
            tick();
        end
        INST_READY = 1'b0;
        total++; if (n_pop - n0 != 6) begin bad++; $display("FAIL stream_pops: got %0d want 6", n_pop - n0); end
    endtask

    task automatic test_backpressure();
        int n0;
        RST_N = 1'b0;
        sb_pc.delete();
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++; if (ROM_ADDR !== 16'h0002) begin bad++; $display("FAIL bp_addr: got %h want 0002", ROM_ADDR); end
        total++; if (INST !== 16'h5C00 || INST_VALID !== 1'b1) begin bad++; $display("FAIL bp_head: got %h v=%b want 5C00 v=1", INST, INST_VALID); end
        for (int i = 0; i < 5; i++) sb_pc.push_back(16'(i));
        n0 = n_pop;
        INST_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if (INST_VALID !== 1'b1 || INST_PC !== 16'(i)) begin bad++; $display("FAIL bp_drain[%0d]: got pc=%h v=%b want pc=%h v=1", i, INST_PC, INST_VALID, 16'(i)); end
            tick();
        end
        INST_READY = 1'b0;
        total++; if (n_pop - n0 != 5 || sb_pc.size() != 0) begin bad++; $display("FAIL bp_pops: got %0d left=%0d want 5 left=0", n_pop - n0, sb_pc.size()); end
    endtask

    task automatic test_jump();
        int n0;
        INST_READY = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        JUMP = 1'b1; JUMP_ADDR = 16'h0010;
        tick();
        JUMP = 1'b0;
        total++; if (INST_VALID !== 1'b0 || ROM_ADDR !== 16'h0010) begin bad++; $display("FAIL jump_flush: got v=%b addr=%h want v=0 addr=0010", INST_VALID, ROM_ADDR); end
        tick();
        for (int i = 0; i < 3; i++) sb_pc.push_back(16'h0010 + 16'(i));
        n0 = n_pop;
        INST_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (INST_VALID !== 1'b1 || INST_PC !== 16'h0010 + 16'(i)) begin bad++; $display("FAIL jump_seq[%0d]: got pc=%h v=%b want pc=%h", i, INST_PC, INST_VALID, 16'h0010 + 16'(i)); end
            tick();
        end
        INST_READY = 1'b0;
        total++; if (n_pop - n0 != 3 || sb_pc.size() != 0) begin bad++; $display("FAIL jump_pops: got %0d left=%0d want 3 left=0", n_pop - n0, sb_pc.size()); end
    endtask

    task automatic test_halt();
        int n0;
        INST_READY = 1'b0;
        JUMP = 1'b1; JUMP_ADDR = 16'h0040;
        tick();
        JUMP = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        total++; if (STOPPED !== 1'b1 || ROM_ADDR !== 16'h0042 || INST_VALID !== 1'b1) begin bad++; $display("FAIL halt_enter: got stop=%b addr=%h v=%b want 1/0042/1", STOPPED, ROM_ADDR, INST_VALID); end
        sb_pc.push_back(16'h0040);
        sb_pc.push_back(16'h0041);
        n0 = n_pop;
        INST_READY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            total++; if (INST_VALID !== 1'b1) begin bad++; $display("FAIL halt_drain[%0d]: got v=%b want 1", i, INST_VALID); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            total++; if (INST_VALID !== 1'b0 || ROM_ADDR !== 16'h0042 || STOPPED !== 1'b1) begin bad++; $display("FAIL halt_idle[%0d]: got v=%b addr=%h stop=%b want 0/0042/1", i, INST_VALID, ROM_ADDR, STOPPED); end
            tick();
        end
        total++; if (n_pop - n0 != 2 || sb_pc.size() != 0) begin bad++; $display("FAIL halt_pops: got %0d left=%0d want 2 left=0", n_pop - n0, sb_pc.size()); end
        INST_READY = 1'b0;
        JUMP = 1'b1; JUMP_ADDR = 16'h0003;
        tick();
        JUMP = 1'b0;
        total++; if (STOPPED !== 1'b0 || ROM_ADDR !== 16'h0003 || INST_VALID !== 1'b0) begin bad++; $display("FAIL halt_resume: got stop=%b addr=%h v=%b want 0/0003/0", STOPPED, ROM_ADDR, INST_VALID); end
        tick();
        total++; if (INST_PC !== 16'h0003 || INST !== rom_f(16'h0003) || INST_VALID !== 1'b1) begin bad++; $display("FAIL halt_refetch: got %h@%h want %h@0003", INST, INST_PC, rom_f(16'h0003)); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc[3] = '{16'hFFFF, 16'h0000, 16'h0001};
        int n0;
        INST_READY = 1'b1;
        JUMP = 1'b1; JUMP_ADDR = 16'hFFFF;
        n0 = n_pop;
        tick();
        JUMP = 1'b0;
        total++; if (INST_VALID !== 1'b0 || ROM_ADDR !== 16'hFFFF) begin bad++; $display("FAIL wrap_jump: got v=%b addr=%h want 0/FFFF", INST_VALID, ROM_ADDR); end
        tick();
        for (int i = 0; i < 3; i++) sb_pc.push_back(exp_pc[i]);
        for (int i = 0; i < 3; i++) begin
            total++; if (INST_VALID !== 1'b1 || INST_PC !== exp_pc[i]) begin bad++; $display("FAIL wrap_seq[%0d]: got pc=%h v=%b want %h", i, INST_PC, INST_VALID, exp_pc[i]); end
            tick();
        end
        INST_READY = 1'b0;
        total++; if (n_pop - n0 != 3 || sb_pc.size() != 0) begin bad++; $display("FAIL wrap_pops: got %0d left=%0d want 3 left=0", n_pop - n0, sb_pc.size()); end
    endtask

    task automatic test_halt_jump_reset();
        int n0;
        INST_READY = 1'b0;
        HALT_REQ = 1'b1; JUMP = 1'b1; JUMP_ADDR = 16'h0020;
        tick();
        HALT_REQ = 1'b0; JUMP = 1'b0;
        total++; if (STOPPED !== 1'b0 || ROM_ADDR !== 16'h0020) begin bad++; $display("FAIL hj_prio: got stop=%b addr=%h want 0/0020", STOPPED, ROM_ADDR); end
        tick();
        total++; if (INST_VALID !== 1'b1 || INST_PC !== 16'h0020) begin bad++; $display("FAIL hj_fetch: got pc=%h v=%b want 0020 v=1", INST_PC, INST_VALID); end
        for (int i = 0; i < 4; i++) sb_pc.push_back(16'h0020 + 16'(i));
        n0 = n_pop;
        INST_READY = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        #2;
        RST_N = 1'b0;
        #1;
        total++; if (INST_VALID !== 1'b0 || INST !== 16'h0 || ROM_ADDR !== 16'h0 || STOPPED !== 1'b0) begin bad++; $display("FAIL mid_reset: got v=%b inst=%h addr=%h stop=%b want 0/0000/0000/0", INST_VALID, INST, ROM_ADDR, STOPPED); end
        total++; if (n_pop - n0 != 2) begin bad++; $display("FAIL hj_pops: got %0d want 2", n_pop - n0); end
        sb_pc.delete();
        tick();
        for (int i = 0; i < 3; i++) sb_pc.push_back(16'(i));
        n0 = n_pop;
        RST_N = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if (INST_VALID !== 1'b1 || INST_PC !== 16'(i)) begin bad++; $display("FAIL restart[%0d]: got pc=%h v=%b want %h", i, INST_PC, INST_VALID, 16'(i)); end
            tick();
        end
        INST_READY = 1'b0;
        total++; if (n_pop - n0 != 3 || sb_pc.size() != 0) begin bad++; $display("FAIL restart_pops: got %0d left=%0d want 3 left=0", n_pop - n0, sb_pc.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_jump();
        test_halt();
        test_wrap();
        test_halt_jump_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
